// File: rtl/serial_adder.sv
// Multi-cycle adder: {cout, sum} = x + y + cin, computed STEP bits per clock with one slice.
// Define SERIAL_ADDER_OVF_EN to add a registered signed-overflow output (ovf).
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int N  = WIDTH / STEP;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] xs, ys, ss;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [STEP:0]       slice;
    logic [WIDTH+STEP-1:0] ss_cat;
    logic [WIDTH-1:0]    ss_nxt;
    logic                last;

    // The single STEP-bit adder slice, fed from the low end of the operand shifters.
    always_comb begin
        slice  = {1'b0, xs[STEP-1:0]} + {1'b0, ys[STEP-1:0]} + {{STEP{1'b0}}, carry};
        ss_cat = {slice[STEP-1:0], ss};
        ss_nxt = ss_cat[WIDTH+STEP-1:STEP];
        last   = (cnt == LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (last)  state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xs    <= '0;
            ys    <= '0;
            ss    <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else if (state == S_IDLE) begin
            if (start) begin
                xs    <= x;
                ys    <= y;
                ss    <= '0;
                carry <= cin;
                cnt   <= '0;
            end
        end else if (state == S_RUN) begin
            xs    <= xs >> STEP;
            ys    <= ys >> STEP;
            ss    <= ss_nxt;
            carry <= slice[STEP];
            cnt   <= cnt + CW'(1);
        end
    end

    // Result registers move only on the final RUN edge, so they hold across later runs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum  <= '0;
            cout <= 1'b0;
        end else if (state == S_RUN && last) begin
            sum  <= ss_nxt;
            cout <= slice[STEP];
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    // On the last slice the operand MSBs sit at bit STEP-1; recover the carry into that bit.
    logic msb_cin;
    assign msb_cin = slice[STEP-1] ^ xs[STEP-1] ^ ys[STEP-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                       ovf <= 1'b0;
        else if (state == S_RUN && last) ovf <= msb_cin ^ slice[STEP];
    end
`endif

endmodule
